// File: rtl/pipe_stage_fifo_if.sv
// Handshake bundle between a producer stage, the inter-stage buffer and a
// consumer stage. The buffer takes the slave side and the stages take the master side.
interface pipe_stage_fifo_if #(
    parameter int WIDTH = 160,
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    count;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count
    );
endinterface

// File: rtl/pipe_stage_fifo.sv
// Elastic inter-stage pipeline buffer. It holds an opaque WIDTH-bit payload in a
// DEPTH-entry circular queue with valid/ready handshaking and a synchronous flush,
// and it drives BUBBLE on out_data whenever it is empty.
module pipe_stage_fifo #(
    parameter int               WIDTH  = 160,
    parameter int               DEPTH  = 2,
    parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}}
) (
    input logic                 clock,
    input logic                 reset,
    input logic                 flush,
    pipe_stage_fifo_if.slave    bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rp;
    logic [PW-1:0]    r_wp;
    logic [CW-1:0]    r_count;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_push;
    logic             w_pop;
    logic [PW-1:0]    w_rp_nxt;
    logic [PW-1:0]    w_wp_nxt;

    // in_ready looks only at registered occupancy, so a full buffer stays closed
    // during the cycle in which it pops.
    assign w_in_ready  = (r_count < CW'(DEPTH));
    assign w_out_valid = (r_count != '0);
    assign w_push      = bus.in_valid && w_in_ready;
    assign w_pop       = w_out_valid && bus.out_ready;

    // DEPTH may not be a power of two, so the pointers wrap on an explicit compare.
    assign w_rp_nxt = (r_rp == PW'(DEPTH - 1)) ? '0 : r_rp + PW'(1);
    assign w_wp_nxt = (r_wp == PW'(DEPTH - 1)) ? '0 : r_wp + PW'(1);

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_out_valid ? r_mem[r_rp] : BUBBLE;
    assign bus.count     = r_count;

    // Pointer and occupancy bookkeeping. Reset and flush both clear the queue.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_rp    <= '0;
            r_wp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wp <= w_wp_nxt;
            if (w_pop)  r_rp <= w_rp_nxt;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage has no reset. A push in a flush or reset cycle is dropped.
    always_ff @(posedge clock) begin
        if (w_push && !flush && !reset) r_mem[r_wp] <= bus.in_data;
    end
endmodule
